reflet_byte_bridge: RTL and testbench
=====================================

Name: reflet_byte_bridge

Overview:
- Sits directly downstream of the CPU address/RAM-access unit.
- Converts each word-wide CPU memory access (instruction fetch, load, store, push/pop, call/ret) into a sequence of byte accesses on an 8-bit synchronous RAM.
- Reports completion back to the CPU side so the caller can extend its not-ready window.
- Little-endian: byte k of a word lives at address addr+k.

Parameters:
- wordsize, 16, CPU word width in bits; must be a multiple of 8 and at least 8. N = wordsize/8 bytes per access.

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- cpu_req  in  1  access request, sampled only in IDLE
- cpu_addr  in  wordsize  byte address of byte 0
- cpu_wdata  in  wordsize  write data
- cpu_write_en  in  1  1 = write access, 0 = read access
- cpu_rdata  out  wordsize  assembled read word
- cpu_busy  out  1  high while an access is in progress
- cpu_done  out  1  one-cycle completion pulse
- ram_addr  out  wordsize  byte address to RAM
- ram_wdata  out  8  byte write data
- ram_write_en  out  1  byte write strobe
- ram_rdata  in  8  RAM read data, one-cycle latency: valid in the cycle after the address edge

Behaviour:
- All outputs are registered.
- Reset values: cpu_rdata=0, cpu_busy=0, cpu_done=0, ram_addr=0, ram_wdata=0, ram_write_en=0. State=IDLE, byte counter k=0.
- States: IDLE, READ, WRITE.
- IDLE:
  - At edge E0 with cpu_req=1, latch addr/wdata/write_en; set cpu_busy=1; go to READ or WRITE.
  - cpu_req=0 leaves IDLE unchanged; ram_write_en stays 0.
- READ:
  - From E0 to E(N-1), ram_addr = addr+k for k=0..N-1.
  - Byte k is captured from ram_rdata at edge E(k+2) into bits [8k+7:8k] of cpu_rdata.
  - At E(N+1): cpu_busy=0, cpu_done=1, return to IDLE. Latency is N+1 edges from accept (3 for wordsize=16).
  - cpu_rdata is updated bytewise during the access and holds its value until the next read completes. Writes never alter it.
- WRITE:
  - At edge E(k), for k=0..N-1: ram_addr=addr+k, ram_wdata=wdata[8k+7:8k], ram_write_en=1.
  - At E(N): ram_write_en=0, cpu_busy=0, cpu_done=1, return to IDLE. Latency is N edges.
- cpu_done is high for exactly one cycle.
  - A new cpu_req may be accepted at the same edge cpu_done drops, i.e. back-to-back requests are allowed with one idle-sampled cycle.
- cpu_req while busy is ignored, not queued.
  - Changes to cpu_addr/cpu_wdata/cpu_write_en mid-access have no effect.
- Address arithmetic is modulo 2^wordsize: addr+k wraps past all-ones to 0.
- ram_addr holds its last value in IDLE.
- Reset asserted mid-access:
  - At that edge all outputs take their reset values and the FSM goes to IDLE.
  - No further ram_write_en pulse is issued.
  - No cpu_done is issued for the aborted access.
  - Reset has priority over a coincident cpu_req.
- wordsize=8: N=1. Read completes 2 edges after accept; write completes 1 edge after accept.

Test Plan:
- Read, wordsize=16, RAM[0x0010]=0x34, RAM[0x0011]=0x12, req at addr 0x0010 -> ram_addr 0x0010 then 0x0011; cpu_done pulses 3 cycles after accept; cpu_rdata=0x1234.
- Write, wordsize=16, addr 0x0020, wdata 0xBEEF -> two ram_write_en cycles: (0x0020, 0xEF) then (0x0021, 0xBE); cpu_done 2 cycles after accept; RAM readback gives 0xBEEF.
- Wrap, wordsize=16, read at 0xFFFF with RAM[0xFFFF]=0xAA, RAM[0x0000]=0x55 -> ram_addr 0xFFFF then 0x0000; cpu_rdata=0x55AA.
- Busy/back-to-back: hold cpu_req high with a write to 0x0040 then a read of 0x0040 -> second access accepted only after first cpu_done; read returns the written value; no request lost or duplicated.
- Reset mid-write: assert reset at E1 of a 32-bit write to 0x0100 -> only byte 0x0100 written; ram_write_en=0 from E1; cpu_busy=0; no cpu_done pulse.
- wordsize=8 build: read of RAM[0x05]=0x7C -> cpu_done 2 cycles after accept; cpu_rdata=0x7C. Write of 0x3D -> single strobe; cpu_done 1 cycle after accept.

Source files
------------

// File: rtl/reflet_byte_bridge.sv
`default_nettype none
// ============================================================================
// Module      : reflet_byte_bridge
// Description : Turns one word-wide CPU memory access into a run of byte
//               accesses on an 8-bit synchronous RAM (one-cycle read
//               latency). Byte k of a word lives at addr+k (little-endian),
//               and addresses wrap modulo 2^WORDSIZE.
// Ports       : clk, reset         - rising-edge clock, sync active-high reset
//               cpu_req            - access request (only sampled when idle)
//               cpu_addr           - byte address of byte 0
//               cpu_wdata          - write word
//               cpu_write_en       - 1 = write, 0 = read
//               cpu_rdata          - assembled read word (held between reads)
//               cpu_busy           - access in progress
//               cpu_done           - single-cycle completion pulse
//               ram_addr           - byte address to RAM (held when idle)
//               ram_wdata          - byte write data
//               ram_write_en       - byte write strobe
//               ram_rdata          - byte read data, valid one cycle after
//                                    the address was presented
// Parameters  : WORDSIZE - CPU word width; multiple of 8, at least 8.
// Revision    : 1.0 - initial release
// ============================================================================
module reflet_byte_bridge #(
    parameter int WORDSIZE = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cpu_req,
    input  logic [WORDSIZE-1:0] cpu_addr,
    input  logic [WORDSIZE-1:0] cpu_wdata,
    input  logic                cpu_write_en,
    output logic [WORDSIZE-1:0] cpu_rdata,
    output logic                cpu_busy,
    output logic                cpu_done,
    output logic [WORDSIZE-1:0] ram_addr,
    output logic [7:0]          ram_wdata,
    output logic                ram_write_en,
    input  logic [7:0]          ram_rdata
);

    localparam int c_N  = WORDSIZE / 8;
    // Counter must reach c_N (last read capture edge).
    localparam int c_CW = $clog2(c_N + 1);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_READ  = 2'd1;
    localparam logic [1:0] c_ST_WRITE = 2'd2;

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    // r_cnt holds (edges since accept) - 1 while an access is running.
    logic [c_CW-1:0]     r_cnt;
    logic [c_CW-1:0]     w_cnt_nxt;
    // Remaining write bytes, shifted down so the next byte is always [7:0].
    logic [WORDSIZE-1:0] r_wshift;
    logic [WORDSIZE-1:0] w_wshift_nxt;

    logic [WORDSIZE-1:0] w_rdata_nxt;
    logic                w_busy_nxt;
    logic                w_done_nxt;
    logic [WORDSIZE-1:0] w_ram_addr_nxt;
    logic [7:0]          w_ram_wdata_nxt;
    logic                w_ram_we_nxt;

    int                  w_cnt;
    logic                w_more_bytes;
    logic                w_read_end;
    logic                w_write_end;

    assign w_cnt        = int'(r_cnt);
    // Another address still has to be issued after this edge's one.
    assign w_more_bytes = (w_cnt < c_N - 1);
    // Last read byte arrives two edges after its address, i.e. edge N+1.
    assign w_read_end   = (w_cnt == c_N);
    assign w_write_end  = (w_cnt == c_N - 1);

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_ST_IDLE;
            r_cnt        <= '0;
            r_wshift     <= '0;
            cpu_rdata    <= '0;
            cpu_busy     <= 1'b0;
            cpu_done     <= 1'b0;
            ram_addr     <= '0;
            ram_wdata    <= '0;
            ram_write_en <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_wshift     <= w_wshift_nxt;
            cpu_rdata    <= w_rdata_nxt;
            cpu_busy     <= w_busy_nxt;
            cpu_done     <= w_done_nxt;
            ram_addr     <= w_ram_addr_nxt;
            ram_wdata    <= w_ram_wdata_nxt;
            ram_write_en <= w_ram_we_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (cpu_req) begin
                    w_state_nxt = cpu_write_en ? c_ST_WRITE : c_ST_READ;
                end
            end
            c_ST_READ: begin
                if (w_read_end) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            c_ST_WRITE: begin
                if (w_write_end) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic (next values of the registered outputs)
    // ------------------------------------------------------------------
    always_comb begin
        w_cnt_nxt       = r_cnt;
        w_wshift_nxt    = r_wshift;
        w_rdata_nxt     = cpu_rdata;
        w_busy_nxt      = cpu_busy;
        w_done_nxt      = 1'b0;
        w_ram_addr_nxt  = ram_addr;
        w_ram_wdata_nxt = ram_wdata;
        w_ram_we_nxt    = 1'b0;

        case (r_state)
            c_ST_IDLE: begin
                if (cpu_req) begin
                    w_busy_nxt     = 1'b1;
                    w_cnt_nxt      = '0;
                    w_ram_addr_nxt = cpu_addr;
                    if (cpu_write_en) begin
                        w_ram_wdata_nxt = cpu_wdata[7:0];
                        w_wshift_nxt    = cpu_wdata >> 8;
                        w_ram_we_nxt    = 1'b1;
                    end
                end
            end
            c_ST_READ: begin
                w_cnt_nxt = r_cnt + c_CW'(1);
                if (w_more_bytes) begin
                    w_ram_addr_nxt = ram_addr + WORDSIZE'(1);
                end
                // Byte (cnt-1) is on ram_rdata now; byte 0 needs two edges.
                for (int b = 0; b < c_N; b++) begin
                    if ((w_cnt >= 1) && (w_cnt - 1 == b)) begin
                        w_rdata_nxt[8*b +: 8] = ram_rdata;
                    end
                end
                if (w_read_end) begin
                    w_busy_nxt = 1'b0;
                    w_done_nxt = 1'b1;
                    w_cnt_nxt  = '0;
                end
            end
            c_ST_WRITE: begin
                w_cnt_nxt = r_cnt + c_CW'(1);
                if (w_more_bytes) begin
                    w_ram_addr_nxt  = ram_addr + WORDSIZE'(1);
                    w_ram_wdata_nxt = r_wshift[7:0];
                    w_wshift_nxt    = r_wshift >> 8;
                    w_ram_we_nxt    = 1'b1;
                end
                if (w_write_end) begin
                    w_busy_nxt = 1'b0;
                    w_done_nxt = 1'b1;
                    w_cnt_nxt  = '0;
                end
            end
            default: begin
                w_busy_nxt = 1'b0;
                w_cnt_nxt  = '0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_reflet_byte_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_reflet_byte_bridge
// Description : Directed self-checking bench for reflet_byte_bridge, with
//               16-, 32- and 8-bit instances each attached to a byte RAM
//               model with one-cycle read latency.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reflet_byte_bridge;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    // 16-bit instance
    logic        req16, we16, busy16, done16, rwe16;
    logic [15:0] addr16, wdata16, rdata16, raddr16;
    logic [7:0]  rwd16, rrd16;
    // 32-bit instance
    logic        req32, we32, busy32, done32, rwe32;
    logic [31:0] addr32, wdata32, rdata32, raddr32;
    logic [7:0]  rwd32, rrd32;
    // 8-bit instance
    logic        req8, we8, busy8, done8, rwe8;
    logic [7:0]  addr8, wdata8, rdata8, raddr8;
    logic [7:0]  rwd8, rrd8;

    reflet_byte_bridge #(.WORDSIZE(16)) u_dut16 (
        .clk(clk), .reset(reset), .cpu_req(req16), .cpu_addr(addr16),
        .cpu_wdata(wdata16), .cpu_write_en(we16), .cpu_rdata(rdata16),
        .cpu_busy(busy16), .cpu_done(done16), .ram_addr(raddr16),
        .ram_wdata(rwd16), .ram_write_en(rwe16), .ram_rdata(rrd16)
    );

    reflet_byte_bridge #(.WORDSIZE(32)) u_dut32 (
        .clk(clk), .reset(reset), .cpu_req(req32), .cpu_addr(addr32),
        .cpu_wdata(wdata32), .cpu_write_en(we32), .cpu_rdata(rdata32),
        .cpu_busy(busy32), .cpu_done(done32), .ram_addr(raddr32),
        .ram_wdata(rwd32), .ram_write_en(rwe32), .ram_rdata(rrd32)
    );

    reflet_byte_bridge #(.WORDSIZE(8)) u_dut8 (
        .clk(clk), .reset(reset), .cpu_req(req8), .cpu_addr(addr8),
        .cpu_wdata(wdata8), .cpu_write_en(we8), .cpu_rdata(rdata8),
        .cpu_busy(busy8), .cpu_done(done8), .ram_addr(raddr8),
        .ram_wdata(rwd8), .ram_write_en(rwe8), .ram_rdata(rrd8)
    );

    // Byte RAM models; a preload port lets the stimulus seed contents.
    logic [7:0]  mem16 [0:65535];
    logic [7:0]  mem32 [0:65535];
    logic [7:0]  mem8  [0:255];
    logic        pl_we;
    logic [1:0]  pl_sel;
    logic [15:0] pl_addr;
    logic [7:0]  pl_data;

    always @(posedge clk) begin
        if (pl_we && pl_sel == 2'd0) mem16[pl_addr] <= pl_data;
        else if (rwe16)              mem16[raddr16] <= rwd16;
        rrd16 <= mem16[raddr16];
    end

    always @(posedge clk) begin
        if (pl_we && pl_sel == 2'd1) mem32[pl_addr]        <= pl_data;
        else if (rwe32)              mem32[raddr32[15:0]]  <= rwd32;
        rrd32 <= mem32[raddr32[15:0]];
    end

    always @(posedge clk) begin
        if (pl_we && pl_sel == 2'd2) mem8[pl_addr[7:0]] <= pl_data;
        else if (rwe8)               mem8[raddr8]       <= rwd8;
        rrd8 <= mem8[raddr8];
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [1:0] sel, input logic [15:0] a, input logic [7:0] d);
        pl_sel  = sel;
        pl_addr = a;
        pl_data = d;
        pl_we   = 1'b1;
        tick();
        pl_we   = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        req16 = 1'b0; we16 = 1'b0; addr16 = '0; wdata16 = '0;
        req32 = 1'b0; we32 = 1'b0; addr32 = '0; wdata32 = '0;
        req8  = 1'b0; we8  = 1'b0; addr8  = '0; wdata8  = '0;
        pl_we = 1'b0; pl_sel = 2'd0; pl_addr = '0; pl_data = '0;

        // ---------------- reset state ----------------
        tick();
        tick();
        check("rst16_busy", 64'(busy16), 64'd0);
        check("rst16_outs", 64'({done16, rwe16, rwd16, rdata16, raddr16}), 64'd0);
        check("rst32_outs", 64'({busy32, done32, rwe32, rwd32, raddr32}), 64'd0);
        check("rst32_rdata", 64'(rdata32), 64'd0);
        check("rst8_outs", 64'({busy8, done8, rwe8, rwd8, rdata8, raddr8}), 64'd0);
        reset = 1'b0;
        tick();
        check("idle16_nowrite", 64'({rwe16, busy16, done16}), 64'd0);

        // ---------------- 16-bit read ----------------
        preload(2'd0, 16'h0010, 8'h34);
        preload(2'd0, 16'h0011, 8'h12);
        req16 = 1'b1; we16 = 1'b0; addr16 = 16'h0010;
        tick();                                             // E0
        check("rd16_e0_addr", 64'(raddr16), 64'h0010);
        check("rd16_e0_busy", 64'(busy16), 64'd1);
        req16 = 1'b0;
        tick();                                             // E1
        check("rd16_e1_addr", 64'(raddr16), 64'h0011);
        check("rd16_e1_done", 64'(done16), 64'd0);
        tick();                                             // E2
        check("rd16_e2_done", 64'(done16), 64'd0);
        tick();                                             // E3
        check("rd16_e3_done", 64'({done16, busy16}), 64'b10);
        check("rd16_rdata", 64'(rdata16), 64'h1234);
        tick();                                             // E4
        check("rd16_e4_done", 64'(done16), 64'd0);
        check("rd16_addr_hold", 64'(raddr16), 64'h0011);

        // ---------------- 16-bit write ----------------
        req16 = 1'b1; we16 = 1'b1; addr16 = 16'h0020; wdata16 = 16'hBEEF;
        tick();                                             // E0
        check("wr16_e0", 64'({rwe16, raddr16, rwd16}), 64'({1'b1, 16'h0020, 8'hEF}));
        req16 = 1'b0; we16 = 1'b0;
        tick();                                             // E1
        check("wr16_e1", 64'({rwe16, raddr16, rwd16}), 64'({1'b1, 16'h0021, 8'hBE}));
        check("wr16_e1_done", 64'(done16), 64'd0);
        tick();                                             // E2
        check("wr16_e2", 64'({rwe16, done16, busy16}), 64'b010);
        check("wr16_mem", 64'({mem16[16'h0021], mem16[16'h0020]}), 64'hBEEF);
        check("wr16_rdata_kept", 64'(rdata16), 64'h1234);
        tick();
        check("wr16_done_drop", 64'(done16), 64'd0);

        // ---------------- 16-bit address wrap ----------------
        preload(2'd0, 16'hFFFF, 8'hAA);
        preload(2'd0, 16'h0000, 8'h55);
        req16 = 1'b1; we16 = 1'b0; addr16 = 16'hFFFF;
        tick();                                             // E0
        check("wrap_e0_addr", 64'(raddr16), 64'hFFFF);
        req16 = 1'b0;
        tick();                                             // E1
        check("wrap_e1_addr", 64'(raddr16), 64'h0000);
        tick();
        tick();                                             // E3
        check("wrap_done", 64'(done16), 64'd1);
        check("wrap_rdata", 64'(rdata16), 64'h55AA);

        // ---------------- back-to-back with req held ----------------
        req16 = 1'b1; we16 = 1'b1; addr16 = 16'h0040; wdata16 = 16'hCAFE;
        tick();                                             // E0 write
        check("b2b_e0", 64'({rwe16, raddr16, rwd16}), 64'({1'b1, 16'h0040, 8'hFE}));
        we16 = 1'b0; wdata16 = 16'h1111;                    // read request held, must wait
        tick();                                             // E1
        check("b2b_e1", 64'({rwe16, raddr16, rwd16}), 64'({1'b1, 16'h0041, 8'hCA}));
        tick();                                             // E2
        check("b2b_e2", 64'({rwe16, done16, busy16}), 64'b010);
        tick();                                             // E3 read accepted
        check("b2b_e3", 64'({rwe16, done16, busy16, raddr16}), 64'({3'b001, 16'h0040}));
        req16 = 1'b0;
        tick();                                             // E4
        check("b2b_e4_addr", 64'(raddr16), 64'h0041);
        tick();                                             // E5
        check("b2b_e5_done", 64'(done16), 64'd0);
        tick();                                             // E6
        check("b2b_e6_done", 64'({done16, busy16}), 64'b10);
        check("b2b_rdata", 64'(rdata16), 64'hCAFE);
        tick();
        check("b2b_e7", 64'({done16, busy16}), 64'b00);
        tick();
        check("b2b_e8", 64'({done16, busy16, rwe16}), 64'b000);

        // ---------------- reset in the middle of a 32-bit write ----------------
        preload(2'd1, 16'h0100, 8'h00);
        preload(2'd1, 16'h0101, 8'h00);
        preload(2'd1, 16'h0102, 8'h00);
        preload(2'd1, 16'h0103, 8'h00);
        req32 = 1'b1; we32 = 1'b1; addr32 = 32'h0000_0100; wdata32 = 32'h1122_3344;
        tick();                                             // E0
        check("rst_wr32_e0", 64'({rwe32, raddr32, rwd32}), 64'({1'b1, 32'h0000_0100, 8'h44}));
        reset = 1'b1;                                       // coincident req stays high
        tick();                                             // E1
        check("rst_wr32_e1", 64'({rwe32, busy32, done32, raddr32}), 64'd0);
        reset = 1'b0; req32 = 1'b0; we32 = 1'b0;
        tick();
        check("rst_wr32_after1", 64'({rwe32, busy32, done32}), 64'd0);
        tick();
        check("rst_wr32_after2", 64'({rwe32, busy32, done32}), 64'd0);
        tick();
        check("rst_wr32_after3", 64'({rwe32, busy32, done32}), 64'd0);
        check("rst_wr32_mem0", 64'(mem32[16'h0100]), 64'h44);
        check("rst_wr32_mem123", 64'({mem32[16'h0103], mem32[16'h0102], mem32[16'h0101]}), 64'd0);

        // ---------------- 8-bit build ----------------
        preload(2'd2, 16'h0005, 8'h7C);
        req8 = 1'b1; we8 = 1'b0; addr8 = 8'h05;
        tick();                                             // E0
        check("w8_rd_e0", 64'({busy8, raddr8}), 64'({1'b1, 8'h05}));
        req8 = 1'b0;
        tick();                                             // E1
        check("w8_rd_e1_done", 64'(done8), 64'd0);
        tick();                                             // E2
        check("w8_rd_e2", 64'({done8, busy8}), 64'b10);
        check("w8_rdata", 64'(rdata8), 64'h7C);
        tick();
        req8 = 1'b1; we8 = 1'b1; addr8 = 8'h09; wdata8 = 8'h3D;
        tick();                                             // E0
        check("w8_wr_e0", 64'({rwe8, raddr8, rwd8}), 64'({1'b1, 8'h09, 8'h3D}));
        req8 = 1'b0; we8 = 1'b0;
        tick();                                             // E1
        check("w8_wr_e1", 64'({rwe8, done8, busy8}), 64'b010);
        check("w8_wr_mem", 64'(mem8[8'h09]), 64'h3D);
        check("w8_rdata_kept", 64'(rdata8), 64'h7C);
        tick();
        check("w8_wr_e2", 64'({rwe8, done8, busy8}), 64'b000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
